platform_field: RTL and testbench



---
 rtl/platform_field_pkg.sv | 35 +++
 rtl/platform_field_lfsr16.sv | 34 +++
 rtl/platform_field.sv | 189 ++++++++++++++++++
 tb/tb_platform_field.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/platform_field_pkg.sv
// Shared types, constants and helpers for the platform field block.
package platform_pkg;

    typedef struct packed {
        logic [9:0] y;
        logic [9:0] x;
    } platform_t;

    typedef enum logic [1:0] {IDLE, SCROLL, SCAN, PUBLISH} state_t;

    localparam int FLOOR_Y  = 767;   // "no platform" landing surface
    localparam int FEET_OFS = 80;    // doodle top to feet
    localparam int LAND_TOL = 30;    // how far the feet may sink into a platform and still land
    localparam int X_RANGE  = 240;   // horizontal spread of platform left edges
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Power-up layout: evenly stacked slots with a scrambled horizontal pattern
    localparam int RESET_Y0 = 671;
    localparam int RESET_DY = 84;
    localparam int RESET_X0 = 141;
    localparam int RESET_DX = 97;

    // Fibonacci LFSR, taps 16,14,13,11 (right-shifting form, feedback into bit 15)
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic platform_t reset_slot(input int i, input int x_min);
        platform_t p;
        p.y = 10'(RESET_Y0 - RESET_DY * i);
        p.x = 10'(x_min + ((RESET_X0 + RESET_DX * i) % X_RANGE));
        return p;
    endfunction

endpackage

// File: rtl/platform_field_lfsr16.sv
// 16-bit LFSR that advances by a variable number of steps in one clock.
module lfsr16
    import platform_pkg::*;
#(
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [STEP_W-1:0] step,
    output logic [15:0]       state
);

    logic [15:0] nxt;

    // Chain up to 2**STEP_W-1 single steps, applying the first 'step' of them
    always_comb begin
        nxt = state;
        for (int k = 0; k < (1 << STEP_W) - 1; k++) begin
            if (STEP_W'(k) < step) begin
                nxt = lfsr_next(nxt);
            end
        end
    end

    // State register, seeded on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LFSR_SEED;
        end else begin
            state <= nxt;
        end
    end

endmodule

// File: rtl/platform_field.sv
// Platform set owner: scrolls, respawns, scans for the landing surface and draws platforms.
module platform_field
    import platform_pkg::*;
#(
    parameter int          NUM_PLAT    = 8,
    parameter int          PLAT_W      = 100,
    parameter int          PLAT_H      = 16,
    parameter int          X_MIN       = 301,
    parameter int          SCREEN_H    = 768,
    parameter int          SCROLL_LINE = 300,
    parameter int          MAX_SHIFT   = 16,
    parameter logic [11:0] PLAT_RGB    = 12'h3C3,
    parameter int          FPS         = 50,
    parameter int          CLK         = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [10:0]      doodle_x,
    input  logic [9:0]       doodle_y,
    input  logic [10:0]      beam_x,
    input  logic [9:0]       beam_y,
    output logic [1:0][9:0]  ground,
    output logic [2:0][3:0]  color,
    output logic             is_transparent,
    output logic [15:0]      score,
    output logic             frame_tick
);

    localparam int FRAME_LEN = CLK / FPS;
    localparam int CNT_W     = $clog2(FRAME_LEN);
    localparam int IDX_W     = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;
    localparam int STEP_W    = $clog2(NUM_PLAT + 2);

    if (FRAME_LEN <= NUM_PLAT + 4) begin : g_frame_check
        $error("frame period too short for scroll, scan and publish");
    end

    platform_t          table_q [NUM_PLAT];
    platform_t          scroll_tab [NUM_PLAT];
    state_t             state;
    logic [IDX_W-1:0]   idx;
    platform_t          best;
    logic               best_vld;
    logic [CNT_W-1:0]   frame_cnt;
    logic [15:0]        lfsr_state;
    logic [STEP_W-1:0]  lfsr_step;
    logic [STEP_W-1:0]  n_resp;
    logic [15:0]        r;
    logic [7:0]         b;
    logic [10:0]        ys;
    logic [10:0]        diff;
    logic [10:0]        shift;
    logic [16:0]        score_sum;
    platform_t          cur;
    logic               cand;
    logic               hit_p0;

    lfsr16 #(.STEP_W(STEP_W)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (lfsr_step),
        .state (lfsr_state)
    );

    // Frame counter; frame_tick is a registered pulse on wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt  <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (frame_cnt == CNT_W'(FRAME_LEN - 1));
            frame_cnt  <= (frame_cnt == CNT_W'(FRAME_LEN - 1)) ? '0 : frame_cnt + 1'b1;
        end
    end

    // Scroll amount, scrolled/respawned table and LFSR step count for this frame
    always_comb begin
        diff = 11'(SCROLL_LINE) - {1'b0, doodle_y};
        if ({1'b0, doodle_y} < 11'(SCROLL_LINE)) begin
            shift = (diff > 11'(MAX_SHIFT)) ? 11'(MAX_SHIFT) : diff;
        end else begin
            shift = '0;
        end
        score_sum  = {1'b0, score} + {6'd0, shift};
        r          = lfsr_state;
        b          = '0;
        ys         = '0;
        n_resp     = '0;
        scroll_tab = table_q;
        for (int i = 0; i < NUM_PLAT; i++) begin
            ys = {1'b0, table_q[i].y} + shift;
            if (ys >= 11'(SCREEN_H)) begin
                b                = r[7:0];
                scroll_tab[i].y  = {6'd0, r[3:0]};
                scroll_tab[i].x  = 10'(X_MIN) +
                                   {2'b00, (b > 8'(X_RANGE)) ? b - 8'd128 : b};
                r                = lfsr_next(r);
                n_resp           = n_resp + 1'b1;
            end else begin
                scroll_tab[i].y  = ys[9:0];
            end
        end
        lfsr_step = (state == SCROLL) ? n_resp + 1'b1 : '0;
    end

    // Landing candidate test for the slot under scan
    always_comb begin
        cur  = table_q[idx];
        cand = ({1'b0, cur.x} <= doodle_x) &&
               (doodle_x <= {1'b0, cur.x} + 11'(PLAT_W - 1)) &&
               ({1'b0, cur.y} + 11'(LAND_TOL) >= {1'b0, doodle_y} + 11'(FEET_OFS));
    end

    // Frame FSM: scroll the table, scan one slot per cycle, publish the best landing surface
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            best      <= '0;
            best_vld  <= 1'b0;
            score     <= '0;
            ground[0] <= 10'(FLOOR_Y);
            ground[1] <= '0;
            for (int i = 0; i < NUM_PLAT; i++) begin
                table_q[i] <= reset_slot(i, X_MIN);
            end
        end else begin
            case (state)
                IDLE: begin
                    if (frame_tick) state <= SCROLL;
                end
                SCROLL: begin
                    table_q  <= scroll_tab;
                    score    <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    idx      <= '0;
                    best_vld <= 1'b0;
                    state    <= SCAN;
                end
                SCAN: begin
                    if (cand && (!best_vld || cur.y < best.y)) begin
                        best     <= cur;
                        best_vld <= 1'b1;
                    end
                    if (idx == IDX_W'(NUM_PLAT - 1)) begin
                        state <= PUBLISH;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                PUBLISH: begin
                    if (best_vld) begin
                        ground <= {best.x, best.y};
                    end else begin
                        ground <= {10'd0, 10'(FLOOR_Y)};
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pixel hit test against every platform
    always_comb begin
        hit_p0 = 1'b0;
        for (int i = 0; i < NUM_PLAT; i++) begin
            if (({1'b0, table_q[i].x} <= beam_x) &&
                (beam_x < {1'b0, table_q[i].x} + 11'(PLAT_W)) &&
                ({1'b0, table_q[i].y} <= {1'b0, beam_y}) &&
                ({1'b0, beam_y} < {1'b0, table_q[i].y} + 11'(PLAT_H))) begin
                hit_p0 = 1'b1;
            end
        end
    end

    // Registered draw output; colour holds its last value on misses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color          <= '0;
            is_transparent <= 1'b1;
        end else if (hit_p0) begin
            color          <= PLAT_RGB;
            is_transparent <= 1'b0;
        end else begin
            is_transparent <= 1'b1;
        end
    end

endmodule

// File: tb/tb_platform_field.sv
// Directed bench for platform_field with a short 100-cycle frame.
module tb_platform_field;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [10:0]     doodle_x;
    logic [9:0]      doodle_y;
    logic [10:0]     beam_x;
    logic [9:0]      beam_y;
    logic [1:0][9:0] ground;
    logic [2:0][3:0] color;
    logic            is_transparent;
    logic [15:0]     score;
    logic            frame_tick;

    always #5 clk = ~clk;

    platform_field #(.CLK(100), .FPS(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .doodle_x       (doodle_x),
        .doodle_y       (doodle_y),
        .beam_x         (beam_x),
        .beam_y         (beam_y),
        .ground         (ground),
        .color          (color),
        .is_transparent (is_transparent),
        .score          (score),
        .frame_tick     (frame_tick)
    );

    int passed = 0;
    int total  = 0;

    int          my [8];
    int          mx [8];
    logic [15:0] mlfsr;
    int          mscore;

    typedef struct {
        int bx;
        int by;
        bit hit;
    } vec_t;
    vec_t vecs [13];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            my[i] = 671 - 84 * i;
            mx[i] = 301 + ((141 + 97 * i) % 240);
        end
        mlfsr  = 16'hACE1;
        mscore = 0;
    endtask

    task automatic model_scroll(input int dy);
        int sh;
        int bb;
        sh = (dy < 300) ? ((300 - dy > 16) ? 16 : 300 - dy) : 0;
        for (int i = 0; i < 8; i++) begin
            if (my[i] + sh >= 768) begin
                bb    = int'(mlfsr[7:0]);
                my[i] = int'(mlfsr[3:0]);
                mx[i] = 301 + ((bb > 240) ? bb - 128 : bb);
                mlfsr = lfsr_step(mlfsr);
            end else begin
                my[i] = my[i] + sh;
            end
        end
        mlfsr  = lfsr_step(mlfsr);
        mscore = (mscore + sh > 65535) ? 65535 : mscore + sh;
    endtask

    task automatic model_ground(input int dx, input int dy, output int gy, output int gx);
        gy = 767;
        gx = 0;
        for (int i = 0; i < 8; i++) begin
            if (mx[i] <= dx && dx <= mx[i] + 99 && my[i] + 30 >= dy + 80 && my[i] < gy) begin
                gy = my[i];
                gx = mx[i];
            end
        end
    endtask

    task automatic probe(input int bx, input int by, input bit exp_hit, input string name);
        @(negedge clk);
        beam_x = 11'(bx);
        beam_y = 10'(by);
        @(posedge clk);
        #1;
        chk({name, " transparent"}, int'(is_transparent), exp_hit ? 0 : 1);
        if (exp_hit) chk({name, " color"}, int'(color), 'h3C3);
    endtask

    task automatic run_frame(input int dx, input int dy, input string name);
        int n;
        int gy;
        int gx;
        @(negedge clk);
        doodle_x = 11'(dx);
        doodle_y = 10'(dy);
        n = 0;
        while (!frame_tick && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, " frame_tick seen"}, int'(frame_tick), 1);
        @(posedge clk);
        #1;
        chk({name, " frame_tick pulse"}, int'(frame_tick), 0);
        repeat (13) @(posedge clk);
        #1;
        model_scroll(dy);
        model_ground(dx, dy, gy, gx);
        chk({name, " ground y"}, int'(ground[0]), gy);
        chk({name, " ground x"}, int'(ground[1]), gx);
        chk({name, " score"}, int'(score), mscore);
    endtask

    initial begin
        int n;
        vecs[0]  = '{442, 671, 1'b1};
        vecs[1]  = '{441, 671, 1'b0};
        vecs[2]  = '{541, 671, 1'b1};
        vecs[3]  = '{542, 671, 1'b0};
        vecs[4]  = '{442, 686, 1'b1};
        vecs[5]  = '{442, 687, 1'b0};
        vecs[6]  = '{442, 670, 1'b0};
        vecs[7]  = '{304, 167, 1'b1};
        vecs[8]  = '{303, 167, 1'b0};
        vecs[9]  = '{539, 587, 1'b1};
        vecs[10] = '{401, 83,  1'b1};
        vecs[11] = '{500, 98,  1'b1};
        vecs[12] = '{501, 98,  1'b0};

        rst_n    = 1'b0;
        doodle_x = 11'd472;
        doodle_y = 10'd687;
        beam_x   = 11'd442;
        beam_y   = 10'd671;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset ground y", int'(ground[0]), 767);
        chk("reset ground x", int'(ground[1]), 0);
        chk("reset score", int'(score), 0);
        chk("reset transparent", int'(is_transparent), 1);
        chk("reset color", int'(color), 0);
        chk("reset frame_tick", int'(frame_tick), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            probe(vecs[i].bx, vecs[i].by, vecs[i].hit, $sformatf("vec%0d", i));
        end

        run_frame(472, 687, "f1 no landing");
        run_frame(472, 591, "f2 slot0 landing");
        run_frame(472, 250, "f3 shift16");
        probe(442, 687, 1'b1, "slot0 moved top");
        probe(442, 686, 1'b0, "slot0 moved above");
        run_frame(472, 290, "f4 shift10");
        probe(442, 697, 1'b1, "slot0 shift10 top");
        probe(442, 696, 1'b0, "slot0 shift10 above");

        for (int f = 0; f < 5; f++) begin
            run_frame(472, 250, $sformatf("climb%0d", f));
        end
        probe(mx[0], my[0], 1'b1, "respawn corner");
        probe(mx[0] + 99, my[0] + 15, 1'b1, "respawn far corner");
        probe(mx[0] - 1, my[0], 1'b0, "respawn left edge");
        probe(442, 761, 1'b0, "old slot0 gone");

        // Reset in the middle of a scan after a scrolling frame
        @(negedge clk);
        doodle_y = 10'd250;
        n = 0;
        while (!frame_tick && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("midscan frame_tick seen", int'(frame_tick), 1);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midscan reset ground y", int'(ground[0]), 767);
        chk("midscan reset ground x", int'(ground[1]), 0);
        chk("midscan reset score", int'(score), 0);
        chk("midscan reset transparent", int'(is_transparent), 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        probe(442, 671, 1'b1, "restored slot0");
        probe(442, 687, 1'b0, "restored below slot0");
        run_frame(472, 591, "post reset landing");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
